// File: rtl/down_sample_sched_pkg.sv
// Shared types and helpers for the down_sample op scheduler.
package down_sample_sched_pkg;

    localparam int DS_CTRL_W = 16;

    typedef logic [3:0][DS_CTRL_W-1:0] ctrl_vars_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    // (ac,ay,ax) > (bc,by,bx) in raster order; operands are one bit wider so 2y+1 fits
    function automatic logic lex_gt(input logic [DS_CTRL_W:0] ac, input logic [DS_CTRL_W:0] ay,
                                    input logic [DS_CTRL_W:0] ax, input logic [DS_CTRL_W:0] bc,
                                    input logic [DS_CTRL_W:0] by, input logic [DS_CTRL_W:0] bx);
        return (ac > bc) || ((ac == bc) && ((ay > by) || ((ay == by) && (ax > bx))));
    endfunction

    function automatic ctrl_vars_t pack_cv(input logic [DS_CTRL_W-1:0] c,
                                           input logic [DS_CTRL_W-1:0] y,
                                           input logic [DS_CTRL_W-1:0] x);
        ctrl_vars_t cv;
        cv[0] = '0;
        cv[1] = c;
        cv[2] = y;
        cv[3] = x;
        return cv;
    endfunction

endpackage

// File: rtl/down_sample_loop_counter.sv
// Three-level (c,y,x) raster counter that parks on its last element and flags done.
module down_sample_loop_counter #(
    parameter int W     = 16,
    parameter int X_MAX = 63,
    parameter int Y_MAX = 63,
    parameter int C_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] c,
    output logic [W-1:0] y,
    output logic [W-1:0] x,
    output logic         last,
    output logic         done
);

    localparam logic [W-1:0] XM = W'(X_MAX);
    localparam logic [W-1:0] YM = W'(Y_MAX);
    localparam logic [W-1:0] CM = W'(C_MAX);

    logic [W-1:0] c_q, c_d, y_q, y_d, x_q, x_d;
    logic         done_q, done_d;

    assign last = (x_q == XM) && (y_q == YM) && (c_q == CM);

    always_comb begin
        c_d    = c_q;
        y_d    = y_q;
        x_d    = x_q;
        done_d = done_q;
        if (clr) begin
            c_d    = '0;
            y_d    = '0;
            x_d    = '0;
            done_d = 1'b0;
        end else if (inc && !done_q) begin
            if (last) begin
                done_d = 1'b1;
            end else if (x_q != XM) begin
                x_d = x_q + W'(1);
            end else begin
                x_d = '0;
                if (y_q != YM) begin
                    y_d = y_q + W'(1);
                end else begin
                    y_d = '0;
                    c_d = c_q + W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q    <= '0;
            y_q    <= '0;
            x_q    <= '0;
            done_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            y_q    <= y_d;
            x_q    <= x_d;
            done_q <= done_d;
        end
    end

    assign c    = c_q;
    assign y    = y_q;
    assign x    = x_q;
    assign done = done_q;

endmodule

// File: rtl/down_sample_op_scheduler.sv
// Issues input write, 2x2 avg-pool compute and output read enables for one frame.
// state | meaning
// IDLE  | no frame active, all enables low
// RUN   | frame in flight, ops fire as their dependencies allow
// DONE  | last output element handed off, waiting for start
module down_sample_op_scheduler
    import down_sample_sched_pkg::*;
#(
    parameter int IN_W   = 64,
    parameter int IN_H   = 64,
    parameter int CH     = 4,
    parameter int CTRL_W = DS_CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  hw_in_wen,
    output logic [4*CTRL_W-1:0]   hw_in_ctrl_vars,
    output logic                  pool_ren,
    output logic                  pool_wen,
    output logic [4*CTRL_W-1:0]   pool_ctrl_vars,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_ren,
    output logic [4*CTRL_W-1:0]   out_ctrl_vars,
    output logic                  busy,
    output logic                  done
);

    sched_state_t state_q, state_d;

    logic [CTRL_W-1:0] ic, iy, ix, pc, py, px, oc, oy, ox;
    logic in_last, in_done, comp_last, comp_done, out_last, out_done;
    logic running, cnt_clr, dep_ok, out_hs;
    logic unused_flags;

    assign running = (state_q == RUN);
    assign cnt_clr = flush || (start && !running);

    down_sample_loop_counter #(.W(CTRL_W), .X_MAX(IN_W-1), .Y_MAX(IN_H-1), .C_MAX(CH-1)) u_in_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(hw_in_wen),
        .c(ic), .y(iy), .x(ix), .last(in_last), .done(in_done)
    );

    down_sample_loop_counter #(.W(CTRL_W), .X_MAX(IN_W/2-1), .Y_MAX(IN_H/2-1), .C_MAX(CH-1)) u_comp_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(pool_ren),
        .c(pc), .y(py), .x(px), .last(comp_last), .done(comp_done)
    );

    down_sample_loop_counter #(.W(CTRL_W), .X_MAX(IN_W/2-1), .Y_MAX(IN_H/2-1), .C_MAX(CH-1)) u_out_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(out_hs),
        .c(oc), .y(oy), .x(ox), .last(out_last), .done(out_done)
    );

    assign unused_flags = in_last ^ comp_last ^ out_done;

    // The window's bottom-right pixel (c,2y+1,2x+1) is written once the input counter has moved past it.
    assign dep_ok = in_done || lex_gt({1'b0, ic}, {1'b0, iy}, {1'b0, ix},
                                      {1'b0, pc}, {py, 1'b1}, {px, 1'b1});

    assign in_ready  = running && !in_done;
    assign hw_in_wen = in_valid && in_ready;
    assign pool_ren  = running && !comp_done && dep_ok;
    assign pool_wen  = pool_ren;
    assign out_valid = running && (comp_done || lex_gt({1'b0, pc}, {1'b0, py}, {1'b0, px},
                                                       {1'b0, oc}, {1'b0, oy}, {1'b0, ox}));
    assign out_ren   = out_valid;
    assign out_hs    = out_valid && out_ready;
    assign busy      = running;
    assign done      = (state_q == DONE);

    assign hw_in_ctrl_vars = pack_cv(ic, iy, ix);
    assign pool_ctrl_vars  = pack_cv(pc, py, px);
    assign out_ctrl_vars   = pack_cv(oc, oy, ox);

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (out_hs && out_last) state_d = DONE;
                DONE:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_down_sample_op_scheduler.sv
// Scoreboard bench for down_sample_op_scheduler: expected coordinate streams and a cycle model.
module tb_down_sample_op_scheduler;

    localparam int IW   = 64;
    localparam int IH   = 64;
    localparam int NC   = 4;
    localparam int NIN  = IW * IH * NC;
    localparam int NOUT = NIN / 4;

    logic        clk = 1'b0;
    logic        rst, flush, start, in_valid, out_ready;
    logic        in_ready, hw_in_wen, pool_ren, pool_wen, out_valid, out_ren, busy, done;
    logic [63:0] hw_in_ctrl_vars, pool_ctrl_vars, out_ctrl_vars;

    down_sample_op_scheduler #(.IN_W(IW), .IN_H(IH), .CH(NC), .CTRL_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .hw_in_wen(hw_in_wen), .hw_in_ctrl_vars(hw_in_ctrl_vars),
        .pool_ren(pool_ren), .pool_wen(pool_wen), .pool_ctrl_vars(pool_ctrl_vars),
        .out_valid(out_valid), .out_ready(out_ready), .out_ren(out_ren),
        .out_ctrl_vars(out_ctrl_vars), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] q_in[$];
    logic [63:0] q_pool[$];
    logic [63:0] q_out[$];

    bit          m_run = 0, m_done = 0, prev_stall = 0;
    int          in_cnt = 0, pool_cnt = 0, out_cnt = 0, out_hs_total = 0;
    int          cyc = 0, first_hs = -1, first_pool = -1, first_ov = -1;
    logic [63:0] last_out = '0, prev_oc = '0;
    bit          in_rand = 0, out_rand = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ctrl_vars: [0]=0, [1]=c, [2]=y, [3]=x, 16 bits each
    function automatic logic [63:0] mk(input int c, input int y, input int x);
        return {x[15:0], y[15:0], c[15:0], 16'h0000};
    endfunction

    // linear index of the pixel (c,2y+1,2x+1) the p-th pool output depends on
    function automatic int dep_idx(input int p);
        int c, y, x;
        c = p / ((IW/2) * (IH/2));
        y = (p / (IW/2)) % (IH/2);
        x = p % (IW/2);
        return c * IW * IH + (2*y + 1) * IW + 2*x + 1;
    endfunction

    task automatic clear_model();
        m_run = 0; m_done = 0; prev_stall = 0;
        in_cnt = 0; pool_cnt = 0; out_cnt = 0;
        q_in.delete(); q_pool.delete(); q_out.delete();
    endtask

    // monitor: model check of every enable each cycle, scoreboard pops on each fired op
    always @(negedge clk) begin
        bit exp_ir, exp_pr, exp_ov, was_run;
        cyc++;
        if (rst) begin
            check("reset_enables", {56'd0, in_ready, hw_in_wen, pool_ren, pool_wen,
                                    out_valid, out_ren, busy, done}, 64'd0);
            check("reset_ctrl_vars", hw_in_ctrl_vars | pool_ctrl_vars | out_ctrl_vars, 64'd0);
            clear_model();
        end else begin
            was_run = m_run;
            exp_ir  = m_run && (in_cnt < NIN);
            exp_pr  = m_run && (pool_cnt < NOUT) && ((in_cnt == NIN) || (in_cnt > dep_idx(pool_cnt)));
            exp_ov  = m_run && (out_cnt < pool_cnt);
            check("cycle_enables",
                  {56'd0, in_ready, hw_in_wen, pool_ren, pool_wen, out_valid, out_ren, busy, done},
                  {56'd0, exp_ir, in_valid && exp_ir, exp_pr, exp_pr, exp_ov, exp_ov, m_run, m_done});
            if (prev_stall) check("out_hold_stable", out_ctrl_vars, prev_oc);
            prev_stall = out_valid && !out_ready;
            prev_oc    = out_ctrl_vars;
            if (flush) begin
                clear_model();
            end else begin
                if (hw_in_wen) begin
                    check("in_ctrl_vars", hw_in_ctrl_vars, (q_in.size() > 0) ? q_in.pop_front() : '1);
                    if (first_hs < 0) first_hs = cyc;
                    in_cnt++;
                end
                if (pool_ren) begin
                    check("pool_ctrl_vars", pool_ctrl_vars, (q_pool.size() > 0) ? q_pool.pop_front() : '1);
                    if (first_pool < 0) first_pool = cyc;
                    pool_cnt++;
                end
                if (out_valid && first_ov < 0) first_ov = cyc;
                if (out_valid && out_ready) begin
                    check("out_ctrl_vars", out_ctrl_vars, (q_out.size() > 0) ? q_out.pop_front() : '1);
                    last_out = out_ctrl_vars;
                    out_cnt++;
                    out_hs_total++;
                    if (out_cnt == NOUT) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
                if (start && !was_run) begin
                    m_run = 1; m_done = 0; prev_stall = 0;
                    in_cnt = 0; pool_cnt = 0; out_cnt = 0;
                    first_hs = -1; first_pool = -1; first_ov = -1;
                end
            end
        end
    end

    // stream-edge driver: gapless or 50% random per mode
    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            in_valid  = in_rand  ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready = out_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic push_frame();
        for (int c = 0; c < NC; c++)
            for (int y = 0; y < IH; y++)
                for (int x = 0; x < IW; x++)
                    q_in.push_back(mk(c, y, x));
        for (int c = 0; c < NC; c++)
            for (int y = 0; y < IH/2; y++)
                for (int x = 0; x < IW/2; x++) begin
                    q_pool.push_back(mk(c, y, x));
                    q_out.push_back(mk(c, y, x));
                end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        push_frame();
        out_hs_total = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!m_done && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("frame_done_in_budget", {63'd0, m_done}, 64'd1);
        check("done_port", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_inputs(input int n, input int budget);
        int k = 0;
        while (in_cnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("inputs_reached", {63'd0, in_cnt >= n}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_ctrl_vars", hw_in_ctrl_vars | pool_ctrl_vars | out_ctrl_vars, 64'd0);
        check("idle_ready_busy", {62'd0, in_ready, busy}, 64'd0);

        // gapless frame, full-rate output
        pulse_start();
        wait_done(20000);
        check("f1_out_count", 64'(out_hs_total), 64'd4096);
        check("f1_pool_latency", 64'(first_pool - first_hs), 64'd66);
        check("f1_out_latency", 64'(first_ov - first_pool), 64'd1);
        check("f1_last_out", last_out, mk(3, 31, 31));

        // flush mid-frame
        pulse_start();
        wait_inputs(1000, 3000);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_enables", {59'd0, hw_in_wen, pool_ren, out_valid, busy, done}, 64'd0);

        // clean frame after flush with random input gaps and output backpressure
        in_rand = 1; out_rand = 1;
        pulse_start();
        wait_done(60000);
        check("f3_out_count", 64'(out_hs_total), 64'd4096);
        check("f3_last_out", last_out, mk(3, 31, 31));

        // async reset mid-frame
        in_rand = 0; out_rand = 0;
        pulse_start();
        wait_inputs(1000, 3000);
        @(posedge clk); #1 rst = 1'b1;
        #2;
        check("rst_async_enables", {60'd0, busy, in_ready, pool_ren, out_valid}, 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        pulse_start();
        wait_done(20000);
        check("f4_out_count", 64'(out_hs_total), 64'd4096);
        check("f4_last_out", last_out, mk(3, 31, 31));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
